// File: rtl/code_search_pkg.sv
// Shared types and constants for the code-phase search controller.
// Holds the FSM state encoding, fixed key/bin widths and default parameter values.
// Imported by code_search_acc and code_search_ctrl.
package code_search_pkg;

    localparam int BIN_W       = 11;
    localparam int KEY_W       = 10;
    localparam int PWR_W_DEF   = 32;
    localparam int DWELL_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SLEW,
        ST_SETTLE,
        ST_DWELL,
        ST_EVAL,
        ST_DONE
    } state_t;

endpackage

// File: rtl/code_search_acc.sv
// Saturating dwell accumulator and dump counter for one code-phase bin.
// Ports: clk/rstn, clr (zero acc and count), add (accumulate din), dwell (target count),
//        acc (running sum, sticks at all-ones), last (combinational: this add completes the dwell).
module code_search_acc
    import code_search_pkg::*;
#(
    parameter int PWR_W   = PWR_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
)
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               clr,
    input  logic               add,
    input  logic [PWR_W-1:0]   din,
    input  logic [DWELL_W-1:0] dwell,
    output logic [PWR_W-1:0]   acc,
    output logic               last
);

    logic [DWELL_W-1:0] cnt;
    logic [PWR_W:0]     sum;
    logic [DWELL_W:0]   cnt_inc;

    // One extra bit on the sum exposes the carry used for saturation.
    assign sum     = {1'b0, acc} + {1'b0, din};
    assign cnt_inc = {1'b0, cnt} + (DWELL_W+1)'(1);
    // Flag the dump that brings the count up to the configured dwell so the
    // controller can leave DWELL on the same edge that stores the final sum.
    assign last    = add && (cnt_inc == {1'b0, dwell});

    always_ff @(posedge clk) begin
        if (!rstn) begin
            acc <= '0;
            cnt <= '0;
        end else if (clr) begin
            acc <= '0;
            cnt <= '0;
        end else if (add) begin
            acc <= sum[PWR_W] ? '1 : sum[PWR_W-1:0];
            cnt <= cnt_inc[DWELL_W-1:0];
        end
    end

endmodule

// File: rtl/code_search_ctrl.sv
// Serial code-phase search: loads a PRN key, steps through bins by slewing the code
// generator, accumulates dwell power per bin and reports the strongest bin.
// Ports: start/abort control, cfg_* (latched at start), dump_enable/corr_power from the
//        correlator, prn/slew strobes to the code generator, busy/done/cfg_err/best_* status.
module code_search_ctrl
    import code_search_pkg::*;
#(
    parameter int PWR_W   = PWR_W_DEF,
    parameter int DWELL_W = DWELL_W_DEF
)
(
    input  logic               clk,
    input  logic               rstn,
    input  logic               start,
    input  logic               abort,
    input  logic [KEY_W-1:0]   cfg_prn_key,
    input  logic [BIN_W-1:0]   cfg_step,
    input  logic [BIN_W-1:0]   cfg_num_bins,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic               dump_enable,
    input  logic [PWR_W-1:0]   corr_power,
    output logic [KEY_W-1:0]   prn_key,
    output logic               prn_key_enable,
    output logic [BIN_W-1:0]   code_slew,
    output logic               slew_enable,
    output logic               busy,
    output logic               done,
    output logic               cfg_err,
    output logic [BIN_W-1:0]   best_bin,
    output logic [PWR_W-1:0]   best_power
);

    state_t             state, state_n;
    logic [KEY_W-1:0]   key_q, key_n;
    logic [BIN_W-1:0]   step_q, step_n;
    logic [BIN_W-1:0]   nbins_q, nbins_n;
    logic [DWELL_W-1:0] dwell_q, dwell_n;
    logic [BIN_W-1:0]   bin, bin_n;
    logic [KEY_W-1:0]   prn_key_n;
    logic [BIN_W-1:0]   code_slew_n;
    logic               cfg_err_n;
    logic [BIN_W-1:0]   best_bin_n;
    logic [PWR_W-1:0]   best_power_n;

    logic               acc_clr, acc_add, acc_last;
    logic [PWR_W-1:0]   acc;

    // The first dump after a load/slew covers a partial code period, so it only
    // clears the accumulator; subsequent dumps in DWELL are summed.
    assign acc_clr = (state == ST_SETTLE) && dump_enable;
    assign acc_add = (state == ST_DWELL)  && dump_enable;

    code_search_acc #(.PWR_W(PWR_W), .DWELL_W(DWELL_W)) u_acc (
        .clk   (clk),
        .rstn  (rstn),
        .clr   (acc_clr),
        .add   (acc_add),
        .din   (corr_power),
        .dwell (dwell_q),
        .acc   (acc),
        .last  (acc_last)
    );

    always_comb begin
        state_n      = state;
        key_n        = key_q;
        step_n       = step_q;
        nbins_n      = nbins_q;
        dwell_n      = dwell_q;
        bin_n        = bin;
        prn_key_n    = prn_key;
        code_slew_n  = code_slew;
        cfg_err_n    = cfg_err;
        best_bin_n   = best_bin;
        best_power_n = best_power;

        // Abort freezes every result register; in IDLE it also masks start.
        if (abort && state != ST_IDLE) begin
            state_n = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && !abort) begin
                        key_n        = cfg_prn_key;
                        step_n       = cfg_step;
                        nbins_n      = cfg_num_bins;
                        dwell_n      = cfg_dwell;
                        cfg_err_n    = 1'b0;
                        best_bin_n   = '0;
                        best_power_n = '0;
                        if (cfg_num_bins == '0 || cfg_dwell == '0) begin
                            cfg_err_n = 1'b1;
                            state_n   = ST_DONE;
                        end else begin
                            prn_key_n = cfg_prn_key;
                            bin_n     = '0;
                            state_n   = ST_LOAD;
                        end
                    end
                end
                ST_LOAD:   state_n = ST_SETTLE;
                ST_SLEW:   state_n = ST_SETTLE;
                ST_SETTLE: if (dump_enable) state_n = ST_DWELL;
                ST_DWELL:  if (acc_last)    state_n = ST_EVAL;
                ST_EVAL: begin
                    if (bin == '0 || acc > best_power) begin
                        best_bin_n   = bin;
                        best_power_n = acc;
                    end
                    if (bin == nbins_q - BIN_W'(1)) begin
                        state_n = ST_DONE;
                    end else begin
                        bin_n       = bin + BIN_W'(1);
                        code_slew_n = step_q;
                        state_n     = ST_SLEW;
                    end
                end
                ST_DONE:   state_n = ST_IDLE;
                default:   state_n = ST_IDLE;
            endcase
        end
    end

    // Strobes and status are registered from the next state so each one is
    // high exactly while the FSM sits in the matching state.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state          <= ST_IDLE;
            key_q          <= '0;
            step_q         <= '0;
            nbins_q        <= '0;
            dwell_q        <= '0;
            bin            <= '0;
            prn_key        <= '0;
            prn_key_enable <= 1'b0;
            code_slew      <= '0;
            slew_enable    <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            cfg_err        <= 1'b0;
            best_bin       <= '0;
            best_power     <= '0;
        end else begin
            state          <= state_n;
            key_q          <= key_n;
            step_q         <= step_n;
            nbins_q        <= nbins_n;
            dwell_q        <= dwell_n;
            bin            <= bin_n;
            prn_key        <= prn_key_n;
            prn_key_enable <= (state_n == ST_LOAD);
            code_slew      <= code_slew_n;
            slew_enable    <= (state_n == ST_SLEW);
            busy           <= (state_n != ST_IDLE);
            done           <= (state_n == ST_DONE);
            cfg_err        <= cfg_err_n;
            best_bin       <= best_bin_n;
            best_power     <= best_power_n;
        end
    end

endmodule
